// File: rtl/colour_decode_if.sv
// colour_decode pixel/result bus: valid/ready pixel input and valid/ready
// phase/magnitude result output. The master side produces pixels and
// consumes results; the slave side is the decoder.
interface colour_decode_if;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  red;
   logic [7:0]  green;
   logic [7:0]  blue;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] phase;
   logic [7:0]  log_mag;

   modport master (
      output in_valid, red, green, blue, out_ready,
      input  in_ready, out_valid, phase, log_mag
   );

   modport slave (
      input  in_valid, red, green, blue, out_ready,
      output in_ready, out_valid, phase, log_mag
   );
endinterface

// File: rtl/colour_decode.sv
// colour_decode: inverse of the phase/magnitude colour mapper.
// Accepts one RGB pixel, finds the hue sector, recovers the in-sector
// fraction with a 6-step restoring divider and returns the phase word and
// brightness. Fixed 7-cycle latency from accept to out_valid.
module colour_decode (
   input  logic            clk,
   input  logic            rst,
   colour_decode_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, PREP, CALC, DONE} state_t;

   state_t      state;

   // captured pixel
   logic [7:0]  r_q, g_q, b_q;

   // divider and sector state
   logic [13:0] rem_q;
   logic [7:0]  den_q;
   logic [5:0]  quot_q;
   logic [2:0]  cnt_q;
   logic [7:0]  base_q;
   logic [7:0]  max_q;

   // registered outputs
   logic        in_ready_q;
   logic        out_valid_q;
   logic [15:0] phase_q;
   logic [7:0]  log_mag_q;

   // PREP combinational results
   logic [7:0]  mx, mn;
   logic [7:0]  num;
   logic [7:0]  den;
   logic [7:0]  base;
   logic [13:0] dividend;

   // CALC combinational results
   logic [13:0] trial;
   logic        take;
   logic [13:0] rem_nxt;
   logic [5:0]  quot_nxt;
   logic [8:0]  hue9;
   logic [7:0]  hue;
   logic [7:0]  mag;

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.phase     = phase_q;
   assign bus.log_mag   = log_mag_q;

   // Sector selection, numerator/denominator and scaled dividend from the captured pixel.
   always_comb begin
      num  = '0;
      base = '0;
      mx   = r_q;
      mn   = r_q;
      if (g_q > mx) mx = g_q;
      if (b_q > mx) mx = b_q;
      if (g_q < mn) mn = g_q;
      if (b_q < mn) mn = b_q;

      if (r_q >= g_q && r_q >= b_q) begin
         if (g_q >= b_q) begin
            base = 8'd0;
            num  = g_q - b_q;
         end else begin
            base = 8'd214;
            num  = r_q - b_q;
         end
      end else if (g_q >= b_q) begin
         if (r_q >= b_q) begin
            base = 8'd43;
            num  = g_q - r_q;
         end else begin
            base = 8'd86;
            num  = b_q - r_q;
         end
      end else begin
         if (r_q >= g_q) begin
            base = 8'd172;
            num  = r_q - g_q;
         end else begin
            base = 8'd129;
            num  = b_q - g_q;
         end
      end

      den = mx - mn;
      // gray pixel: fraction 0 in sector 0, keep the divider busy for the normal count
      if (mx == mn) begin
         num  = '0;
         den  = 8'd1;
         base = '0;
      end

      dividend = {6'b0, num} * 14'd43;
   end

   // One restoring-division step at bit position cnt_q, plus the final hue/brightness.
   always_comb begin
      trial    = {6'b0, den_q} << cnt_q;
      take     = (rem_q >= trial);
      rem_nxt  = take ? (rem_q - trial) : rem_q;
      quot_nxt = take ? (quot_q | (6'd1 << cnt_q)) : quot_q;

      hue9 = {1'b0, base_q} + {3'b0, quot_nxt};
      hue  = hue9[8] ? 8'hFF : hue9[7:0];

      if (max_q == 8'd0)
         mag = 8'd0;
      else if (max_q == 8'hFF)
         mag = 8'hFF;
      else
         mag = max_q + 8'd1;
   end

   // Control FSM with divider datapath and registered handshake/result outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         r_q         <= '0;
         g_q         <= '0;
         b_q         <= '0;
         rem_q       <= '0;
         den_q       <= '0;
         quot_q      <= '0;
         cnt_q       <= '0;
         base_q      <= '0;
         max_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         phase_q     <= '0;
         log_mag_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_q        <= bus.red;
                  g_q        <= bus.green;
                  b_q        <= bus.blue;
                  in_ready_q <= 1'b0;
                  state      <= PREP;
               end
            end
            PREP: begin
               rem_q  <= dividend;
               den_q  <= den;
               quot_q <= '0;
               cnt_q  <= 3'd5;
               base_q <= base;
               max_q  <= mx;
               state  <= CALC;
            end
            CALC: begin
               rem_q  <= rem_nxt;
               quot_q <= quot_nxt;
               cnt_q  <= cnt_q - 3'd1;
               // the count-0 step's quotient bit feeds the result directly
               if (cnt_q == 3'd0) begin
                  phase_q     <= {hue - 8'd128, 8'h00};
                  log_mag_q   <= mag;
                  out_valid_q <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/colour_decode.md
# colour_decode

Inverse of the phase/magnitude colour mapper: accepts one 24-bit RGB pixel over a valid/ready handshake and recovers the 16-bit phase word and 8-bit brightness that the forward mapper would have used to produce it. It sits on the verification and readback path, after the colour mapper, so pixel streams can be turned back into phase/magnitude for checking and analysis. Hue recovery uses a 6-cycle iterative restoring divider, so each pixel has a fixed latency of 7 cycles.

## Interface
Parameters:
- none. All widths are fixed.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  pixel on red/green/blue is valid
- in_ready  output  1  block can accept a pixel; high only in IDLE
- red  input  8  red channel
- green  input  8  green channel
- blue  input  8  blue channel
- out_valid  output  1  phase and log_mag hold a result
- out_ready  input  1  consumer accepts the result
- phase  output  16  recovered phase; 0x0000 = -π, 0xFFFF = π; bits [7:0] are always 0
- log_mag  output  8  recovered brightness

## Operation
- State machine IDLE -> PREP -> CALC -> DONE -> IDLE.
- IDLE: in_ready=1. When in_valid is high, red/green/blue are registered and the state moves to PREP.
- PREP: compute the sector, numerator and denominator from the registered pixel. Priority rules:
  - R>=G and R>=B: sector 0 (base 0, num G-B) if G>=B, else sector 5 (base 214, num R-B).
  - Else if G>=B: sector 1 (base 43, num G-R) if R>=B, else sector 2 (base 86, num B-R).
  - Else: sector 4 (base 172, num R-G) if R>=G, else sector 3 (base 129, num B-G).
  - den = max-min. This always satisfies num <= den.
- Gray pixel (max==min): force num=0 and den=1. The result is f=0, base 0, hue 0. Latency is unchanged.
- Dividend = num*43, 14 bits (maximum 10965). Divisor = den, 8 bits.
- CALC: restoring division, 6 iterations (the quotient is at most 43, which fits in 6 bits).
  - Iteration k (k = 5 down to 0) compares the remainder with den<<k and sets quotient bit k.
  - A 3-bit counter loads 5 in PREP and decrements each CALC cycle. The state leaves CALC after the count-0 iteration.
- Hue = base + f, computed in 9 bits and saturated to 255. This saturation only matters in sector 5.
- phase = {hue - 8'd128, 8'h00}, computed mod 256 on the upper byte.
- log_mag = 0 if max==0; else min(max+1, 255). This inverts the forward brightness truncation (255*b)>>8.
- DONE: out_valid=1. phase and log_mag are held stable until out_ready is high, then the state returns to IDLE.
- in_ready is 0 in PREP, CALC and DONE. in_valid is ignored in those states.
- No new pixel is accepted in the same cycle a result is consumed.

## Timing
- Reset (asynchronous, any state): state=IDLE, in_ready=1, out_valid=0, phase=0, log_mag=0. The counter, input registers and divider state are all cleared.
- A pixel in flight at reset is discarded and no result is produced for it.
- Accept on edge N (IDLE with in_valid high). PREP runs on edge N+1. The CALC iterations run on edges N+2..N+7.
- out_valid rises after edge N+7: latency is 7 cycles.
- The result is consumed on the first edge in DONE where out_ready is high. out_valid falls and in_ready rises after that edge.
- Minimum pixel period is 9 cycles when out_ready is held high.
- phase and log_mag update only on the entry to DONE. They keep their last value in IDLE/PREP/CALC and are not cleared on handshake.
- If out_ready is already high when DONE is entered, the result is consumed on the next edge: out_valid is high for exactly 1 cycle.

## Test plan
- After reset, check in_ready=1, out_valid=0, phase=0x0000, log_mag=0. Then apply (255,0,0) with out_ready=1 -> out_valid exactly 7 cycles after accept, phase=0x8000, log_mag=255.
- (0,255,0) -> sector 1, f=43, hue 86, phase=0xD600, log_mag=255. (200,100,0) -> f=21, phase=0x9500, log_mag=201.
- Gray (127,127,127) -> phase=0x8000, log_mag=128. Black (0,0,0) -> phase=0x8000, log_mag=0.
- Sector 5 saturation: (255,0,1) -> f=42, hue saturates to 255, phase=0x7F00, log_mag=255.
- Backpressure: hold out_ready low for 10 cycles in DONE while toggling in_valid and pixel data -> out_valid, phase and log_mag stable, in_ready=0, no extra pixel accepted. Then raise out_ready -> one handshake, then IDLE.
- Reset asserted asynchronously on the 3rd CALC cycle -> outputs return to reset values immediately, no out_valid. The next pixel, (0,255,0), gives the correct result with a 7-cycle latency.
